net_weight_calc: RTL and testbench

Consumer end of the tare path in the scale (Balanca) design. Takes the 12-bit tare offset produced upstream, or a tare captured from the live reading, and subtracts it from the load-cell sample stream. Tracks reading stability and produces a registered net weight with sign and overload flags for the display/BCD stage.

---
 rtl/net_weight_calc.sv | 206 ++++++++++++++++++++
 tb/tb_net_weight_calc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/net_weight_calc.sv
// Net weight stage: subtracts the tare from the load-cell samples, tracks reading stability, and flags overload and negative results.
// Optional NET_AVG_EN: the net path uses a 4-sample moving average instead of the raw sample.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no sample seen since reset
// SETTLING | counting consecutive in-tolerance samples
// STABLE   | STABLE_CNT consecutive samples within TOL; capture allowed
module net_weight_calc #(
    parameter int W          = 12,
    parameter int STABLE_CNT = 4,
    parameter int TOL        = 2,
    parameter int MAX_LOAD   = 4000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sample,
    input  logic         sample_valid,
    input  logic [W-1:0] tare_in,
    input  logic         tare_load,
    input  logic         tare_capture,
    output logic [W-1:0] net,
    output logic         net_valid,
    output logic         negative,
    output logic         overload,
    output logic         stable,
    output logic [W-1:0] tare_value
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_STABLE   = 2'd2
    } state_t;

    localparam logic [3:0]   STABLE_CNT_W = 4'(STABLE_CNT);
    localparam logic [W:0]   TOL_W        = (W+1)'(TOL);
    localparam logic [W-1:0] MAX_LOAD_W   = W'(MAX_LOAD);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] last_q;
    logic [W-1:0] tare_q;
    logic         stable_q;

    logic [W:0]   diff;
    logic         in_tol;

    logic [W-1:0] eff_sample;
    logic [W-1:0] net_d;
    logic         negative_d;
    logic         overload_d;

    logic [W-1:0] net_q;
    logic         net_valid_q;
    logic         negative_q;
    logic         overload_q;

    // Widened by one bit so that 0 vs 4095 is a large difference, not a wrap to 1.
    always_comb begin
        if (sample >= last_q) begin
            diff = {1'b0, sample} - {1'b0, last_q};
        end else begin
            diff = {1'b0, last_q} - {1'b0, sample};
        end
        in_tol = (diff <= TOL_W);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_valid) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLING;
                    cnt_d   = 4'd1;
                end
                ST_SETTLING: begin
                    if (in_tol) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == STABLE_CNT_W) begin
                            state_d = ST_STABLE;
                        end
                    end else begin
                        cnt_d = 4'd1;
                    end
                end
                ST_STABLE: begin
                    if (!in_tol) begin
                        state_d = ST_SETTLING;
                        cnt_d   = 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= (state_d == ST_STABLE);
            if (sample_valid) begin
                last_q <= sample;
            end
        end
    end

    // Capture reads last_q before this cycle's sample lands in it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tare_q <= '0;
        end else if (tare_load) begin
            tare_q <= tare_in;
        end else if (tare_capture && (state_q == ST_STABLE)) begin
            tare_q <= last_q;
        end
    end

`ifdef NET_AVG_EN
    logic [W-1:0] win_q [3];
    logic         primed_q;
    logic [W+1:0] win_sum;

    always_comb begin
        win_sum = {2'b00, sample} + {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]};
        if (primed_q) begin
            eff_sample = win_sum[W+1:2];
        end else begin
            eff_sample = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q[0] <= '0;
            win_q[1] <= '0;
            win_q[2] <= '0;
            primed_q <= 1'b0;
        end else if (sample_valid) begin
            if (!primed_q) begin
                win_q[0] <= sample;
                win_q[1] <= sample;
                win_q[2] <= sample;
                primed_q <= 1'b1;
            end else begin
                win_q[0] <= sample;
                win_q[1] <= win_q[0];
                win_q[2] <= win_q[1];
            end
        end
    end
`else
    always_comb begin
        eff_sample = sample;
    end
`endif

    always_comb begin
        net_d      = '0;
        negative_d = 1'b0;
        overload_d = 1'b0;
        if (eff_sample > MAX_LOAD_W) begin
            net_d      = '1;
            overload_d = 1'b1;
        end else if (eff_sample >= tare_q) begin
            net_d = eff_sample - tare_q;
        end else begin
            net_d      = tare_q - eff_sample;
            negative_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            net_q       <= '0;
            net_valid_q <= 1'b0;
            negative_q  <= 1'b0;
            overload_q  <= 1'b0;
        end else begin
            net_valid_q <= sample_valid;
            if (sample_valid) begin
                net_q      <= net_d;
                negative_q <= negative_d;
                overload_q <= overload_d;
            end
        end
    end

    assign net        = net_q;
    assign net_valid  = net_valid_q;
    assign negative   = negative_q;
    assign overload   = overload_q;
    assign stable     = stable_q;
    assign tare_value = tare_q;

endmodule

// File: tb/tb_net_weight_calc.sv
// Directed bench for net_weight_calc: tare load/capture, net sign/overload, stability tracking, reset.
module tb_net_weight_calc;

    logic        clk;
    logic        rst_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic [11:0] tare_in;
    logic        tare_load;
    logic        tare_capture;
    logic [11:0] net;
    logic        net_valid;
    logic        negative;
    logic        overload;
    logic        stable;
    logic [11:0] tare_value;

    int tests;
    int failures;

    net_weight_calc #(.W(12), .STABLE_CNT(4), .TOL(2), .MAX_LOAD(4000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .tare_in      (tare_in),
        .tare_load    (tare_load),
        .tare_capture (tare_capture),
        .net          (net),
        .net_valid    (net_valid),
        .negative     (negative),
        .overload     (overload),
        .stable       (stable),
        .tare_value   (tare_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("check %s", tag);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, return at the following negedge.
    task automatic step(input logic sv, input logic [11:0] s, input logic tl,
                        input logic [11:0] ti, input logic tc);
        sample_valid = sv;
        sample       = s;
        tare_load    = tl;
        tare_in      = ti;
        tare_capture = tc;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        tare_load    = 1'b0;
        tare_capture = 1'b0;
    endtask

    task automatic put(input logic [11:0] s);
        step(1'b1, s, 1'b0, 12'd0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
    endtask

    initial begin
        tests        = 0;
        failures     = 0;
        rst_n        = 1'b0;
        sample       = 12'd0;
        sample_valid = 1'b0;
        tare_in      = 12'd0;
        tare_load    = 1'b0;
        tare_capture = 1'b0;
        idle();
        idle();
        check("rst_net", 32'(net), 32'd0);
        check("rst_net_valid", 32'(net_valid), 32'd0);
        check("rst_negative", 32'(negative), 32'd0);
        check("rst_overload", 32'(overload), 32'd0);
        check("rst_stable", 32'(stable), 32'd0);
        check("rst_tare", 32'(tare_value), 32'd0);
        rst_n = 1'b1;

        step(1'b0, 12'd0, 1'b1, 12'd123, 1'b0);
        check("tare_load_123", 32'(tare_value), 32'd123);
        check("no_valid_before_sample", 32'(net_valid), 32'd0);

        put(12'd500);
        check("n500_valid", 32'(net_valid), 32'd1);
        check("n500_net", 32'(net), 32'd377);
        check("n500_neg", 32'(negative), 32'd0);
        idle();
        check("n500_pulse_one_cycle", 32'(net_valid), 32'd0);
        check("n500_net_holds", 32'(net), 32'd377);

        put(12'd100);
        check("n100_net", 32'(net), 32'd23);
        check("n100_neg", 32'(negative), 32'd1);

        put(12'd4001);
        check("n4001_net", 32'(net), 32'd4095);
        check("n4001_ovl", 32'(overload), 32'd1);
        check("n4001_neg", 32'(negative), 32'd0);

        put(12'd4000);
        check("n4000_ovl", 32'(overload), 32'd0);
        check("n4000_net", 32'(net), 32'd3877);

        put(12'd1000);
        put(12'd1001);
        put(12'd1002);
        check("stab_before_4th", 32'(stable), 32'd0);
        put(12'd1001);
        check("stab_after_4th", 32'(stable), 32'd1);
        check("n1001_net", 32'(net), 32'd878);

        put(12'd1010);
        check("jump_unstable", 32'(stable), 32'd0);
        check("jump_state_settling", 32'(dut.state_q), 32'd1);
        check("jump_cnt_one", 32'(dut.cnt_q), 32'd1);

        step(1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
        check("capture_ignored_settling", 32'(tare_value), 32'd123);

        put(12'd1001);
        put(12'd1001);
        put(12'd1001);
        check("stab1001_not_yet", 32'(stable), 32'd0);
        put(12'd1001);
        check("stab1001", 32'(stable), 32'd1);
        step(1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
        check("capture_1001", 32'(tare_value), 32'd1001);
        put(12'd1001);
        check("after_capture_net", 32'(net), 32'd0);
        check("after_capture_neg", 32'(negative), 32'd0);

        step(1'b0, 12'd0, 1'b1, 12'd0, 1'b0);
        check("tare_zero", 32'(tare_value), 32'd0);
        step(1'b1, 12'd300, 1'b1, 12'd50, 1'b1);
        check("same_cycle_old_tare", 32'(net), 32'd300);
        check("same_cycle_load_wins", 32'(tare_value), 32'd50);
        put(12'd300);
        check("new_tare_net", 32'(net), 32'd250);

        put(12'd300);
        put(12'd300);
        check("stab300", 32'(stable), 32'd1);
        step(1'b1, 12'd310, 1'b0, 12'd0, 1'b1);
        check("capture_prev_last", 32'(tare_value), 32'd300);
        check("capture_sample_old_tare", 32'(net), 32'd260);
        check("capture_sample_unstable", 32'(stable), 32'd0);

        put(12'd310);
        put(12'd310);
        put(12'd310);
        check("stab310", 32'(stable), 32'd1);
        rst_n = 1'b0;
        idle();
        check("mid_rst_net", 32'(net), 32'd0);
        check("mid_rst_valid", 32'(net_valid), 32'd0);
        check("mid_rst_neg", 32'(negative), 32'd0);
        check("mid_rst_ovl", 32'(overload), 32'd0);
        check("mid_rst_stable", 32'(stable), 32'd0);
        check("mid_rst_tare", 32'(tare_value), 32'd0);
        check("mid_rst_state_idle", 32'(dut.state_q), 32'd0);
        check("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
        rst_n = 1'b1;

        put(12'd400);
        check("post_rst_n1", 32'(net), 32'd400);
        check("post_rst_first_settling", 32'(dut.cnt_q), 32'd1);
        put(12'd400);
        check("post_rst_n2", 32'(net), 32'd400);
        put(12'd400);
        check("post_rst_n3", 32'(net), 32'd400);
        put(12'd800);
`ifdef NET_AVG_EN
        check("avg_n4", 32'(net), 32'd500);
`else
        check("raw_n4", 32'(net), 32'd800);
`endif
        check("post_rst_stable_reset", 32'(stable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
